// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit_if
//  Description : Core-request, response and data-memory signals of the LSU.
//  Revision    : 1.0
// ============================================================================
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [31:0] mem_access_addr;
    logic [31:0] mem_wr_val;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [2:0]  mem_data_size;
    logic [31:0] mem_rd_val;

    // master: core plus data memory; slave: the load/store unit itself
    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, mem_rd_val,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned,
        input  mem_access_addr, mem_wr_val, mem_write_en, mem_read_en, mem_data_size
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, mem_rd_val,
        output req_ready, resp_valid, resp_rdata, resp_misaligned,
        output mem_access_addr, mem_wr_val, mem_write_en, mem_read_en, mem_data_size
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Data-memory initiator; splits misaligned half/word requests
//                into byte accesses and reassembles/extends load data.
//  Revision    : 1.0
// ============================================================================
module load_store_unit #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    load_store_unit_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_SPLIT  = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    localparam logic [2:0] c_SZ_B  = 3'b000;
    localparam logic [2:0] c_SZ_H  = 3'b001;
    localparam logic [2:0] c_SZ_W  = 3'b010;
    localparam logic [2:0] c_SZ_BU = 3'b100;
    localparam logic [2:0] c_SZ_HU = 3'b101;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;

    logic        r_write;
    logic [2:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_mis;
    logic [1:0]  r_cnt;
    logic [31:0] r_asm;
    logic [31:0] r_resp_rdata;
    logic        r_resp_mis;

    logic [2:0]  w_norm_size;
    logic        w_mis;
    logic        w_last;
    logic [7:0]  w_split_byte;
    logic [31:0] w_asm_next;

    function automatic logic [31:0] f_extend(input logic [2:0] sz, input logic [31:0] d);
        logic [31:0] v;
        case (sz)
            c_SZ_B:  v = {{24{d[7]}}, d[7:0]};
            c_SZ_H:  v = {{16{d[15]}}, d[15:0]};
            c_SZ_BU: v = {24'd0, d[7:0]};
            c_SZ_HU: v = {16'd0, d[15:0]};
            default: v = d;
        endcase
        return v;
    endfunction

    // Stores have no unsigned forms, so bu/hu collapse onto b/h for them
    always_comb begin
        w_norm_size = c_SZ_W;
        case (bus.req_size)
            3'b000:  w_norm_size = c_SZ_B;
            3'b001:  w_norm_size = c_SZ_H;
            3'b100:  w_norm_size = bus.req_write ? c_SZ_B : c_SZ_BU;
            3'b101:  w_norm_size = bus.req_write ? c_SZ_H : c_SZ_HU;
            default: w_norm_size = c_SZ_W;
        endcase
    end

    always_comb begin
        w_mis = 1'b0;
        if ((w_norm_size == c_SZ_H || w_norm_size == c_SZ_HU) && bus.req_addr[0])
            w_mis = 1'b1;
        if (w_norm_size == c_SZ_W && bus.req_addr[1:0] != 2'b00)
            w_mis = 1'b1;
    end

    assign w_last = (r_size == c_SZ_W) ? (r_cnt == 2'd3) : (r_cnt == 2'd1);

    always_comb begin
        w_split_byte = r_wdata[7:0];
        case (r_cnt)
            2'd0:    w_split_byte = r_wdata[7:0];
            2'd1:    w_split_byte = r_wdata[15:8];
            2'd2:    w_split_byte = r_wdata[23:16];
            default: w_split_byte = r_wdata[31:24];
        endcase
    end

    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[{r_cnt, 3'b000} +: 8] = bus.mem_rd_val[7:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.req_valid)
                    w_state_next = (w_mis && SPLIT_EN) ? c_ST_SPLIT : c_ST_ACCESS;
            end
            c_ST_ACCESS: w_state_next = c_ST_DONE;
            c_ST_SPLIT:  w_state_next = w_last ? c_ST_DONE : c_ST_SPLIT;
            default:     w_state_next = c_ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        bus.req_ready       = 1'b0;
        bus.resp_valid      = 1'b0;
        bus.resp_rdata      = r_resp_rdata;
        bus.resp_misaligned = r_resp_mis;
        bus.mem_access_addr = 32'd0;
        bus.mem_wr_val      = 32'd0;
        bus.mem_write_en    = 1'b0;
        bus.mem_read_en     = 1'b0;
        bus.mem_data_size   = 3'b000;
        case (r_state)
            c_ST_IDLE: bus.req_ready = 1'b1;
            c_ST_ACCESS: begin
                // Without splitting, a misaligned access degrades to the enclosing word
                bus.mem_access_addr = (!SPLIT_EN && r_mis) ? {r_addr[31:2], 2'b00} : r_addr;
                bus.mem_wr_val      = r_wdata;
                bus.mem_data_size   = r_size;
                bus.mem_write_en    = r_write;
                bus.mem_read_en     = !r_write;
            end
            c_ST_SPLIT: begin
                bus.mem_access_addr = r_addr + {30'd0, r_cnt};
                bus.mem_wr_val      = r_write ? {24'd0, w_split_byte} : 32'd0;
                bus.mem_data_size   = r_write ? c_SZ_B : c_SZ_BU;
                bus.mem_write_en    = r_write;
                bus.mem_read_en     = !r_write;
            end
            default: bus.resp_valid = 1'b1;
        endcase
    end

    // Request latch, byte assembly and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write      <= 1'b0;
            r_size       <= 3'b000;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_mis        <= 1'b0;
            r_cnt        <= 2'd0;
            r_asm        <= 32'd0;
            r_resp_rdata <= 32'd0;
            r_resp_mis   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_write <= bus.req_write;
                        r_size  <= w_norm_size;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_mis   <= w_mis;
                        r_cnt   <= 2'd0;
                        r_asm   <= 32'd0;
                    end
                end
                c_ST_ACCESS: begin
                    r_resp_rdata <= r_write ? 32'd0 : f_extend(r_size, bus.mem_rd_val);
                    r_resp_mis   <= r_mis;
                end
                c_ST_SPLIT: begin
                    r_asm <= w_asm_next;
                    r_cnt <= r_cnt + 2'd1;
                    if (w_last) begin
                        r_resp_rdata <= r_write ? 32'd0 : f_extend(r_size, w_asm_next);
                        r_resp_mis   <= r_mis;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
